// File: rtl/tff_pkg.sv
// Shared definitions for the toggle flip-flop bank: operating modes.
package tff_pkg;

  typedef enum logic [1:0] {
    MODE_T    = 2'd0,
    MODE_D    = 2'd1,
    MODE_DIV  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_t;

endpackage

// File: rtl/tff_chan.sv
// One channel of the bank: a q bit, its prescale counter and its change-pulse flop.
module tff_chan
  import tff_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic [CNT_W-1:0] nm1,
  input  logic             data,
  output logic             q,
  output logic             tgl
);

  logic             q_q, q_d;
  logic             tgl_q, tgl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for q and the counter; the >= compare lets a stale, larger count fire at once.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (en) begin
      case (mode)
        MODE_T: begin
          q_d   = q_q ^ data;
          cnt_d = {CNT_W{1'b0}};
        end
        MODE_D: begin
          q_d   = data;
          cnt_d = {CNT_W{1'b0}};
        end
        MODE_DIV: begin
          if (data) begin
            if (cnt_q >= nm1) begin
              q_d   = ~q_q;
              cnt_d = {CNT_W{1'b0}};
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        MODE_HOLD: begin
          cnt_d = {CNT_W{1'b0}};
        end
        default: begin
          cnt_d = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
    tgl_d = en & (q_d != q_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= 1'b0;
      tgl_q <= 1'b0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      q_q   <= q_d;
      tgl_q <= tgl_d;
      cnt_q <= cnt_d;
    end
  end

  assign q   = q_q;
  assign tgl = tgl_q;

endmodule

// File: rtl/tff_bank.sv
// WIDTH-channel T/D/prescaled-toggle flip-flop bank sharing one mode, enable and prescale.
module tff_bank
  import tff_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] div_val,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] tgl
);

  logic [CNT_W-1:0] nm1_s;
  mode_t            mode_s;

  // A prescale of zero behaves as one.
  assign nm1_s  = (div_val == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (div_val - CNT_W'(1));
  assign mode_s = mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    tff_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .mode  (mode_s),
      .nm1   (nm1_s),
      .data  (data[i]),
      .q     (q[i]),
      .tgl   (tgl[i])
    );
  end

endmodule
